// File: rtl/sram_responder_model.sv
// rtl/sram_responder_model.sv - clocked responder standing in for the external async-SRAM pin bus
//
// Purpose: samples the SRAM pin bus on clk, stores written words in an internal
// array and drives SRAM_DQ on reads after READ_LATENCY cycles. Used in place of
// the physical SRAM in simulation and in on-FPGA loopback builds.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   SRAM_DQ      bidirectional data bus, driven only in S_DRIVE
//   SRAM_ADDR    word address (indexes the array directly)
//   SRAM_WE_N    write strobe, active-low
//   SRAM_CE_N    chip enable, active-low
//   SRAM_OE_N    output enable, active-low
//   SRAM_UB_N    upper half-word lane enable, active-low
//   SRAM_LB_N    lower half-word lane enable, active-low
//   write_count  committed writes, wraps 16'hFFFF -> 0
//   violation    sticky protocol-error flag
//
// Optional feature: define SRAM_CHECK_EN to build the protocol checker
// (short WE_N pulse, WE_N low while driving). Without it violation is 0.

module sram_responder_model #(
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 2,
  parameter int MIN_WE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  output logic [15:0]       write_count,
  output logic              violation
);

  localparam int         HALF = DATA_W / 2;
  localparam logic [2:0] RL   = 3'(READ_LATENCY);

  // Out-of-range settings show up as g_bad_params in the elaborated hierarchy.
  if (READ_LATENCY < 1 || READ_LATENCY > 7 || MIN_WE_CYCLES < 1 || MIN_WE_CYCLES > 7) begin : g_bad_params
  end

  typedef enum logic [1:0] {S_IDLE, S_RWAIT, S_DRIVE, S_WRITE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic [15:0]       write_count_q, write_count_d;
  logic [DATA_W-1:0] rdata_q;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic sel, wr, rd, addr_diff;
  logic latch_wr, latch_addr;
  logic commit, load_rdata, dq_oe;

  assign sel       = !SRAM_CE_N;
  assign wr        = sel && !SRAM_WE_N;
  assign rd        = sel && SRAM_WE_N && !SRAM_OE_N;
  assign addr_diff = (SRAM_ADDR != addr_q);

  // State register and latched bus fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ub_n_q        <= 1'b1;
      lb_n_q        <= 1'b1;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ub_n_q        <= ub_n_d;
      lb_n_q        <= lb_n_d;
      write_count_q <= write_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_wr   = 1'b0;
    latch_addr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr) begin
          state_d  = S_WRITE;
          cnt_d    = 3'd1;
          latch_wr = 1'b1;
        end else if (rd) begin
          state_d    = S_RWAIT;
          cnt_d      = 3'd1;
          latch_addr = 1'b1;
        end
      end
      S_RWAIT: begin
        if (wr) begin
          state_d  = S_WRITE;
          cnt_d    = 3'd1;
          latch_wr = 1'b1;
        end else if (!rd) begin
          state_d = S_IDLE;
        end else if (addr_diff) begin
          // Unstable address restarts the access latency
          cnt_d      = 3'd1;
          latch_addr = 1'b1;
        end else if (cnt_q == RL) begin
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DRIVE: begin
        if (!rd) begin
          state_d = S_IDLE;
        end else if (addr_diff) begin
          state_d    = S_RWAIT;
          cnt_d      = 3'd1;
          latch_addr = 1'b1;
        end
      end
      S_WRITE: begin
        if (wr) begin
          // Keep the most recent bus word; commit happens on strobe release
          latch_wr = 1'b1;
          cnt_d    = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch datapath
  always_comb begin
    addr_d  = (latch_wr || latch_addr) ? SRAM_ADDR : addr_q;
    wdata_d = latch_wr ? SRAM_DQ   : wdata_q;
    ub_n_d  = latch_wr ? SRAM_UB_N : ub_n_q;
    lb_n_d  = latch_wr ? SRAM_LB_N : lb_n_q;
  end

  // Outputs and strobes
  always_comb begin
    commit        = (state_q == S_WRITE) && !wr;
    load_rdata    = (state_d == S_DRIVE);
    dq_oe         = (state_q == S_DRIVE);
    write_count_d = commit ? write_count_q + 16'd1 : write_count_q;
  end

  // Array is deliberately not reset; commit is held off by the reset state
  always_ff @(posedge clk) begin
    if (commit) begin
      if (!ub_n_q) mem[addr_q][DATA_W-1:HALF] <= wdata_q[DATA_W-1:HALF];
      if (!lb_n_q) mem[addr_q][HALF-1:0]      <= wdata_q[HALF-1:0];
    end
    if (load_rdata) rdata_q <= mem[addr_d];
  end

  assign SRAM_DQ     = dq_oe ? rdata_q : {DATA_W{1'bz}};
  assign write_count = write_count_q;

`ifdef SRAM_CHECK_EN
  logic violation_q, violation_d;

  always_comb begin
    violation_d = violation_q;
    if (commit && (int'(cnt_q) < MIN_WE_CYCLES)) violation_d = 1'b1;
    // Host driving WE_N low while we own the bus is contention
    if ((state_q == S_DRIVE) && sel && !SRAM_WE_N) violation_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) violation_q <= 1'b0;
    else      violation_q <= violation_d;
  end

  assign violation = violation_q;
`else
  assign violation = 1'b0;
`endif

endmodule
